// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480 timing and the sync-window decode helper
// used by the VGA timing controller.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } run_state_e;

   localparam int DEF_PIX_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_HCNT_W   = 10;
   localparam int DEF_VCNT_W   = 10;

   // True when count lies in [lo, lo+len-1].
   function automatic logic in_window(input int unsigned count,
                                      input int unsigned lo,
                                      input int unsigned len);
      return (count >= lo) && (count < (lo + len));
   endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Run request in, pixel timing out: the link between the register block,
// the timing controller and the frame-buffer / RGB logic.
interface vga_timing_ctrl_if #(
   parameter int HCNT_W = 10,
   parameter int VCNT_W = 10
);
   logic              ENABLE_IN;
   logic              PIX_EN;
   logic [HCNT_W-1:0] X;
   logic [VCNT_W-1:0] Y;
   logic              DE;
   logic              HS;
   logic              VS;
   logic              LINE_START;
   logic              FRAME_START;
   logic              FRAME_END;
   logic              BUSY;

   modport master (
      input  ENABLE_IN,
      output PIX_EN, X, Y, DE, HS, VS, LINE_START, FRAME_START, FRAME_END, BUSY
   );

   modport slave (
      output ENABLE_IN,
      input  PIX_EN, X, Y, DE, HS, VS, LINE_START, FRAME_START, FRAME_END, BUSY
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One wrapping pixel-axis counter; NEXT exposes the value loaded on the
// coming edge so the caller can register decodes in step with COUNT.
module vga_axis_counter #(
   parameter int WIDTH = 10,
   parameter int TOTAL = 800
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CLR,
   input  logic             INC,
   output logic [WIDTH-1:0] COUNT,
   output logic             WRAP,
   output logic [WIDTH-1:0] NEXT
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

   logic [WIDTH-1:0] r_count;

   assign COUNT = r_count;

   always_comb begin
      WRAP = INC && (r_count == LAST);
      if (CLR) begin
         NEXT = {WIDTH{1'b0}};
      end else if (WRAP) begin
         NEXT = {WIDTH{1'b0}};
      end else if (INC) begin
         NEXT = r_count + WIDTH'(1'b1);
      end else begin
         NEXT = r_count;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_count <= {WIDTH{1'b0}};
      end else begin
         r_count <= NEXT;
      end
   end
endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA pixel timing generator with a run/drain FSM so the display only
// starts and stops on frame boundaries.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int PIX_DIV  = DEF_PIX_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int HCNT_W   = DEF_HCNT_W,
   parameter int VCNT_W   = DEF_VCNT_W,
   parameter bit SYNC_POL = 1'b0
) (
   input logic                 CLK,
   input logic                 RESET,
   vga_timing_ctrl_if.master   bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PRE_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PIX_DIV - 1);
   localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);

   if (H_TOTAL > (2 ** HCNT_W)) begin : g_h_width_chk
      $error("vga_timing_ctrl: H_TOTAL does not fit in HCNT_W bits");
   end
   if (V_TOTAL > (2 ** VCNT_W)) begin : g_v_width_chk
      $error("vga_timing_ctrl: V_TOTAL does not fit in VCNT_W bits");
   end

   run_state_e        r_state, w_state_next;
   logic [PRE_W-1:0]  r_pre;
   logic              r_de, r_hs, r_vs;
   logic              w_running, w_clr, w_tick, w_run_next;
   logic [HCNT_W-1:0] w_x, w_x_next;
   logic [VCNT_W-1:0] w_y, w_y_next;
   logic              w_h_wrap, w_v_wrap;

   vga_axis_counter #(.WIDTH(HCNT_W), .TOTAL(H_TOTAL)) u_hcnt (
      .CLK(CLK), .RESET(RESET), .CLR(w_clr), .INC(w_tick),
      .COUNT(w_x), .WRAP(w_h_wrap), .NEXT(w_x_next)
   );

   // Vertical advances only when the horizontal axis wraps; its wrap marks the last pixel of the frame.
   vga_axis_counter #(.WIDTH(VCNT_W), .TOTAL(V_TOTAL)) u_vcnt (
      .CLK(CLK), .RESET(RESET), .CLR(w_clr), .INC(w_h_wrap),
      .COUNT(w_y), .WRAP(w_v_wrap), .NEXT(w_y_next)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (bus.ENABLE_IN) w_state_next = RUN;   else w_state_next = IDLE;
         RUN:     if (!bus.ENABLE_IN) w_state_next = DRAIN; else w_state_next = RUN;
         DRAIN: begin
            if (bus.ENABLE_IN)  w_state_next = RUN;
            else if (w_v_wrap)  w_state_next = IDLE;
            else                w_state_next = DRAIN;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_running       = (r_state != IDLE);
      w_clr           = !w_running;
      w_tick          = w_running && (r_pre == PRE_LAST);
      bus.BUSY        = w_running;
      bus.PIX_EN      = w_tick;
      bus.LINE_START  = w_tick && (w_x == {HCNT_W{1'b0}});
      bus.FRAME_START = w_tick && (w_x == {HCNT_W{1'b0}}) && (w_y == {VCNT_W{1'b0}});
      bus.FRAME_END   = w_v_wrap;
      bus.X           = w_x;
      bus.Y           = w_y;
      bus.DE          = r_de;
      bus.HS          = r_hs;
      bus.VS          = r_vs;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pre <= {PRE_W{1'b0}};
      end else if (!w_running || w_tick) begin
         r_pre <= {PRE_W{1'b0}};
      end else begin
         r_pre <= r_pre + PRE_W'(1'b1);
      end
   end

   assign w_run_next = (w_state_next != IDLE);

   // Decoded from the next counts so DE/HS/VS land on the same edge as X/Y.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_de <= 1'b0;
         r_hs <= ~SYNC_POL;
         r_vs <= ~SYNC_POL;
      end else begin
         r_de <= w_run_next && (32'(w_x_next) < H_ACTIVE) && (32'(w_y_next) < V_ACTIVE);
         r_hs <= (w_run_next && in_window(32'(w_x_next), H_ACTIVE + H_FP, H_SYNC))
                 ? SYNC_POL : ~SYNC_POL;
         r_vs <= (w_run_next && in_window(32'(w_y_next), V_ACTIVE + V_FP, V_SYNC))
                 ? SYNC_POL : ~SYNC_POL;
      end
   end

   logic w_unused;
   assign w_unused = ^{H_LAST, 1'b0};
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA horizontal and vertical pixel counters. Produces the pixel-rate enable, HS/VS, display enable, pixel coordinates and line/frame strobes for the AHB VGA peripheral.
- A run/drain state machine guarantees that the display only starts, and only stops, on frame boundaries.
- Sits between the AHB register block (which drives ENABLE_IN) and the frame-buffer read / RGB output logic.

Parameters:
- PIX_DIV, 4: CLK cycles per pixel; minimum 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HCNT_W, 10: horizontal count width.
- VCNT_W, 10: vertical count width.
- SYNC_POL, 0: asserted level of HS and VS.

Ports:
- CLK  input  1  system clock; the single clock domain.
- RESET  input  1  reset; asynchronous, active-high.
- ENABLE_IN  input  1  run request from the control register.
- PIX_EN  output  1  high on the last CLK cycle of each pixel period.
- X  output  HCNT_W  current horizontal count.
- Y  output  VCNT_W  current vertical count.
- DE  output  1  display enable: X < H_ACTIVE and Y < V_ACTIVE.
- HS  output  1  horizontal sync, at SYNC_POL when asserted.
- VS  output  1  vertical sync, at SYNC_POL when asserted.
- LINE_START  output  1  one-CLK pulse with PIX_EN when X==0.
- FRAME_START  output  1  one-CLK pulse with PIX_EN when X==0 and Y==0.
- FRAME_END  output  1  one-CLK pulse with PIX_EN at X==H_TOTAL-1, Y==V_TOTAL-1.
- BUSY  output  1  high while state != IDLE.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration check: fail if H_TOTAL > 2**HCNT_W or V_TOTAL > 2**VCNT_W.
- Reset values (asynchronous, immediate): state=IDLE; prescaler=0; X=0; Y=0; DE=0; HS=VS=~SYNC_POL; PIX_EN=LINE_START=FRAME_START=FRAME_END=0; BUSY=0.
- State machine, states IDLE, RUN, DRAIN:
  - IDLE: prescaler and counters are held at 0; DE=0; HS/VS deasserted. ENABLE_IN=1 -> RUN on the next edge.
  - RUN: ENABLE_IN=0 -> DRAIN; timing is undisturbed.
  - DRAIN: counting continues. ENABLE_IN=1 -> RUN with no timing glitch. On the FRAME_END cycle (tick at the last pixel): -> IDLE.
  - If ENABLE_IN rises in the same cycle as the DRAIN FRAME_END, the machine goes to RUN; the frame restarts at (0,0) seamlessly.
- Prescaler:
  - Counts 0..PIX_DIV-1 while in RUN or DRAIN.
  - tick = (prescaler==PIX_DIV-1); PIX_EN = tick.
  - With PIX_DIV=1, PIX_EN is constantly high while running.
- Counters:
  - On tick, X increments. At X==H_TOTAL-1, X wraps to 0 and Y increments.
  - At Y==V_TOTAL-1 with X wrapping, Y wraps to 0.
  - Counters never exceed TOTAL-1; there is no off-by-one at wrap.
- Registered outputs:
  - DE, HS and VS are registered and updated on the same edge as X/Y, computed from the next count values. All of X, Y, DE, HS and VS therefore describe the same pixel in every cycle, with zero skew.
  - HS asserted for X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - VS asserted for Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. VS changes only at line wrap.
- First cycle after IDLE->RUN: X=0, Y=0, DE=1.
- FRAME_START is combinational on tick & X==0 & Y==0 & running. The first frame after enable therefore pulses FRAME_START on the first tick.
- Leaving DRAIN to IDLE: on the next edge X=0, Y=0 and DE=0; HS and VS are already deasserted at that point in the frame.
- Reset mid-frame: all outputs return to reset values immediately. After RESET deasserts, operation resumes only through IDLE->RUN.

Decomposition:
- Package vga_timing_pkg holds:
  - run_state_e enum (IDLE, RUN, DRAIN);
  - default 640x480 timing localparams;
  - function in_window(count, lo, len) used for the HS/VS decode.
- One sub-module, vga_axis_counter, is instantiated twice:
  - parameters WIDTH and TOTAL;
  - inputs CLK, RESET, CLR, INC; outputs COUNT, WRAP, NEXT.
  - The vertical instance's INC is the horizontal WRAP.

Test Plan (PIX_DIV=2; H=4/1/2/1 so H_TOTAL=8; V=3/1/1/1 so V_TOTAL=6; SYNC_POL=0):
- Startup: RESET pulse, then ENABLE_IN=1 -> BUSY=1 next edge; first RUN cycle X=0, Y=0, DE=1; PIX_EN on cycles 2, 4, 6...; FRAME_START together with the first PIX_EN.
- Line timing: run one line -> DE high for X 0..3; HS=0 exactly for X=5,6 (4 CLK); X wraps 7->0 with Y 0->1 and LINE_START on the X=0 tick.
- Frame timing: run 2 frames -> VS=0 only for Y=4 (16 CLK); FRAME_END at (7,5); the frame period is 96 CLK between FRAME_START pulses.
- Drain: drop ENABLE_IN at (2,1) -> counting continues to (7,5); BUSY falls on the edge after FRAME_END; X=Y=0; DE=0; HS=VS=1.
- Re-enable in DRAIN: drop ENABLE_IN at (2,1), raise it at (0,3) -> no timing disturbance; the next frame starts at (0,0) with FRAME_START; BUSY stays 1.
- Async reset mid-frame: RESET asserted at (6,4) between clock edges -> HS=VS=1, DE=0, X=Y=0, BUSY=0 immediately, without waiting for a CLK edge; after RESET drops, stays IDLE until ENABLE_IN=1.
